// File: rtl/cache_control.sv
// cache_control: FSM sequencing a 2-way set-associative write-back,
// write-allocate cache datapath through hit, writeback and fill.
module cache_control #(
    parameter bit RESP_REG = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mem_read,
    input  logic       mem_write,
    input  logic       hit0,
    input  logic       hit1,
    input  logic       dirty0,
    input  logic       dirty1,
    input  logic       lru,
    input  logic       pmem_resp,
    output logic       mem_resp,
    output logic       pmem_read,
    output logic       pmem_write,
    output logic [1:0] addrmux_sel,
    output logic [1:0] wemux_sel0,
    output logic [1:0] wemux_sel1,
    output logic       dimux_sel,
    output logic       domux_sel,
    output logic       load_tag0,
    output logic       load_tag1,
    output logic       load_valid0,
    output logic       load_valid1,
    output logic       load_dirty0,
    output logic       load_dirty1,
    output logic       dirty_in,
    output logic       load_lru,
    output logic       lru_in
);
    localparam logic [1:0] ADDR_CACHE0 = 2'd0;
    localparam logic [1:0] ADDR_CACHE1 = 2'd1;
    localparam logic [1:0] ADDR_CPU    = 2'd2;
    localparam logic [1:0] WE_ZEROS    = 2'd0;
    localparam logic [1:0] WE_ONES     = 2'd1;
    localparam logic [1:0] WE_CPU_BE   = 2'd2;
    localparam logic       DI_CPU      = 1'b0;
    localparam logic       DI_MEM      = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        WRITEBACK,
        FILL
    } state_t;

    state_t state;
    logic   victim;
    logic   req;
    logic   hit;
    logic   hitw;
    logic   miss_dirty;
    logic   resp_c;
    logic   domux_c;

    assign req        = mem_read | mem_write;
    assign hit        = hit0 | hit1;
    assign hitw       = ~hit0;
    assign miss_dirty = lru ? dirty1 : dirty0;

    // victim is captured on the miss so a changing lru cannot redirect the fill
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            victim <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) state <= CHECK;
                end
                CHECK: begin
                    if (!req || hit) begin
                        state <= IDLE;
                    end else begin
                        victim <= lru;
                        state  <= miss_dirty ? WRITEBACK : FILL;
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp) state <= FILL;
                end
                FILL: begin
                    if (pmem_resp) state <= CHECK;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        resp_c      = 1'b0;
        domux_c     = 1'b0;
        pmem_read   = 1'b0;
        pmem_write  = 1'b0;
        addrmux_sel = ADDR_CPU;
        wemux_sel0  = WE_ZEROS;
        wemux_sel1  = WE_ZEROS;
        dimux_sel   = DI_CPU;
        load_tag0   = 1'b0;
        load_tag1   = 1'b0;
        load_valid0 = 1'b0;
        load_valid1 = 1'b0;
        load_dirty0 = 1'b0;
        load_dirty1 = 1'b0;
        dirty_in    = 1'b0;
        load_lru    = 1'b0;
        lru_in      = 1'b0;
        case (state)
            CHECK: begin
                if (req && hit) begin
                    resp_c   = 1'b1;
                    domux_c  = hitw;
                    load_lru = 1'b1;
                    lru_in   = ~hitw;
                    if (mem_write) begin
                        if (hitw) wemux_sel1 = WE_CPU_BE;
                        else      wemux_sel0 = WE_CPU_BE;
                        load_dirty0 = ~hitw;
                        load_dirty1 = hitw;
                        dirty_in    = 1'b1;
                    end
                end
            end
            WRITEBACK: begin
                pmem_write  = 1'b1;
                addrmux_sel = victim ? ADDR_CACHE1 : ADDR_CACHE0;
                domux_c     = victim;
            end
            FILL: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    if (victim) wemux_sel1 = WE_ONES;
                    else        wemux_sel0 = WE_ONES;
                    dimux_sel   = DI_MEM;
                    load_tag0   = ~victim;
                    load_tag1   = victim;
                    load_valid0 = ~victim;
                    load_valid1 = victim;
                    load_dirty0 = ~victim;
                    load_dirty1 = victim;
                end
            end
            default: ;
        endcase
    end

    generate
        if (RESP_REG) begin : g_resp_reg
            always_ff @(posedge clk) begin
                if (rst) begin
                    mem_resp  <= 1'b0;
                    domux_sel <= 1'b0;
                end else begin
                    mem_resp  <= resp_c;
                    domux_sel <= domux_c;
                end
            end
        end else begin : g_resp_comb
            assign mem_resp  = resp_c;
            assign domux_sel = domux_c;
        end
    endgenerate
endmodule
